// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response capture
// into a small {pc, instr} FIFO, and redirect handling that drops stale responses.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     instr_out,
  output logic            valid_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_req_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   r_fifo_cnt;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [31:0]     r_fifo_instr [DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_req_fire;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_target_pc;
  logic [CW-1:0]   w_out_less_resp;
  logic            w_unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Credits cover both requests still in memory and entries waiting in the FIFO.
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, r_fifo_cnt};
  assign imem_req_valid = (r_state == ST_RUN) && !redirect_valid && (w_inflight < (CW + 1)'(DEPTH));
  assign imem_req_addr  = r_req_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_empty   = (r_fifo_cnt == CW'(0));
  assign valid_out = !w_empty && !redirect_valid;
  assign pc_out    = w_empty ? {XLEN{1'b0}} : r_fifo_pc[r_rd_ptr];
  assign instr_out = w_empty ? 32'h0000_0000 : r_fifo_instr[r_rd_ptr];
  assign w_pop     = valid_out && !stall;
  assign w_push    = imem_resp_valid && (r_discard == CW'(0));

  assign w_target_pc     = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_out_less_resp = (imem_resp_valid && (r_outstanding != CW'(0))) ?
                           (r_outstanding - CW'(1)) : r_outstanding;
  assign w_unused_bits   = &{1'b0, redirect_pc[1:0]};

  // Control state: FSM, PCs, credit/discard counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req_pc      <= {RESET_PC[XLEN-1:2], 2'b00};
      r_resp_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
      r_outstanding <= CW'(0);
      r_discard     <= CW'(0);
      r_fifo_cnt    <= CW'(0);
      r_rd_ptr      <= PW'(0);
      r_wr_ptr      <= PW'(0);
    end else begin
      r_state <= ST_RUN;
      if (redirect_valid) begin
        // Everything still in memory belongs to the abandoned path.
        r_req_pc      <= w_target_pc;
        r_resp_pc     <= w_target_pc;
        r_outstanding <= w_out_less_resp;
        r_discard     <= w_out_less_resp;
        r_fifo_cnt    <= CW'(0);
        r_rd_ptr      <= PW'(0);
        r_wr_ptr      <= PW'(0);
      end else begin
        if (w_req_fire) begin
          r_req_pc <= r_req_pc + XLEN'(4);
        end else begin
          r_req_pc <= r_req_pc;
        end
        r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
        if (imem_resp_valid && !w_push) begin
          r_discard <= r_discard - CW'(1);
        end else begin
          r_discard <= r_discard;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + XLEN'(4);
          r_wr_ptr  <= ptr_inc(r_wr_ptr);
        end else begin
          r_resp_pc <= r_resp_pc;
          r_wr_ptr  <= r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ptr_inc(r_rd_ptr);
        end else begin
          r_rd_ptr <= r_rd_ptr;
        end
        r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // FIFO storage; a write into the slot being popped is safe since the read is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]    <= {XLEN{1'b0}};
        r_fifo_instr[i] <= 32'h0000_0000;
      end
    end else if (w_push && !redirect_valid) begin
      r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
      r_fifo_instr[r_wr_ptr] <= imem_resp_data;
    end else begin
      r_fifo_pc[r_wr_ptr]    <= r_fifo_pc[r_wr_ptr];
      r_fifo_instr[r_wr_ptr] <= r_fifo_instr[r_wr_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed cycle table, reset-while-full
// sequence, then randomized traffic against a PC-sequence reference model.
module tb_fetch_stage;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        valid_out;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .pc_out(pc_out),
    .instr_out(instr_out), .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        st, rd, rs, rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vout;
    logic [31:0] e_pc;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          pops  = 0;
  logic [31:0] addr_q[$];
  logic [31:0] exp_req, exp_pc;
  logic        prev_hold;
  logic [31:0] prev_pc, prev_instr;
  vec_t        tbl[25];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E96;
  endfunction

  function automatic vec_t mk(input logic st, rd, rs, rv, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_vout, input logic [31:0] e_pc);
    return {st, rd, rs, rv, rpc, e_req, e_addr, e_vout, e_pc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, rd, rs, rv, input logic [31:0] rpc);
    stall           = st;
    imem_req_ready  = rd;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_resp_valid = rs && (addr_q.size() > 0);
    imem_resp_data  = imem_resp_valid ? mem_word(addr_q[0]) : 32'h0000_0000;
  endtask

  task automatic model_reset();
    addr_q.delete();
    exp_req   = RPC;
    exp_pc    = RPC;
    prev_hold = 1'b0;
  endtask

  // Reference: delivered PCs form a +4 sequence from the last target; data must match memory.
  task automatic observe();
    if (redirect_valid) begin
      check("redir_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("redir_valid_out", {31'd0, valid_out}, 32'd0);
    end else begin
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
      if (valid_out && !stall) begin
        check("pc_seq", pc_out, exp_pc);
        check("instr_data", instr_out, mem_word(pc_out));
      end
      if (prev_hold) begin
        check("hold_valid", {31'd0, valid_out}, 32'd1);
        check("hold_pc", pc_out, prev_pc);
        check("hold_instr", instr_out, prev_instr);
      end
    end
    check("credit_bound", {31'd0, addr_q.size() <= DEPTH}, 32'd1);
    prev_hold  = stall && valid_out && !redirect_valid;
    prev_pc    = pc_out;
    prev_instr = instr_out;
    if (redirect_valid) begin
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_pc  = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        addr_q.push_back(imem_req_addr);
        exp_req = exp_req + 32'd4;
      end
      if (valid_out && !stall) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    if (imem_resp_valid) void'(addr_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic        st, rd, rs, rv;
    logic [31:0] rpc;
    tbl[0]  = mk(0,1,0,0,32'h0,            0,32'h0,         0,32'h0);
    tbl[1]  = mk(0,1,0,0,32'h0,            1,RPC+32'h00,    0,32'h0);
    tbl[2]  = mk(0,1,1,0,32'h0,            1,RPC+32'h04,    0,32'h0);
    tbl[3]  = mk(0,1,1,0,32'h0,            1,RPC+32'h08,    1,RPC+32'h00);
    tbl[4]  = mk(0,1,1,0,32'h0,            1,RPC+32'h0C,    1,RPC+32'h04);
    tbl[5]  = mk(0,1,1,0,32'h0,            1,RPC+32'h10,    1,RPC+32'h08);
    tbl[6]  = mk(1,1,1,0,32'h0,            1,RPC+32'h14,    1,RPC+32'h0C);
    tbl[7]  = mk(1,1,1,0,32'h0,            1,RPC+32'h18,    1,RPC+32'h0C);
    tbl[8]  = mk(1,1,1,0,32'h0,            0,32'h0,         1,RPC+32'h0C);
    tbl[9]  = mk(1,1,0,0,32'h0,            0,32'h0,         1,RPC+32'h0C);
    tbl[10] = mk(0,1,0,0,32'h0,            0,32'h0,         1,RPC+32'h0C);
    tbl[11] = mk(0,1,0,0,32'h0,            1,RPC+32'h1C,    1,RPC+32'h10);
    tbl[12] = mk(0,1,1,0,32'h0,            1,RPC+32'h20,    1,RPC+32'h14);
    tbl[13] = mk(0,1,1,0,32'h0,            1,RPC+32'h24,    1,RPC+32'h18);
    tbl[14] = mk(1,1,0,0,32'h0,            1,RPC+32'h28,    1,RPC+32'h1C);
    tbl[15] = mk(1,1,0,1,32'h8000_0102,    0,32'h0,         0,RPC+32'h1C);
    tbl[16] = mk(0,1,1,0,32'h0,            1,RPC+32'h100,   0,32'h0);
    tbl[17] = mk(0,1,1,0,32'h0,            1,RPC+32'h104,   0,32'h0);
    tbl[18] = mk(0,1,1,0,32'h0,            1,RPC+32'h108,   0,32'h0);
    tbl[19] = mk(0,1,1,0,32'h0,            1,RPC+32'h10C,   1,RPC+32'h100);
    tbl[20] = mk(1,1,1,1,32'h8000_0200,    0,32'h0,         0,RPC+32'h104);
    tbl[21] = mk(1,1,0,0,32'h0,            1,RPC+32'h200,   0,32'h0);
    tbl[22] = mk(0,1,1,0,32'h0,            1,RPC+32'h204,   0,32'h0);
    tbl[23] = mk(0,1,1,0,32'h0,            1,RPC+32'h208,   0,32'h0);
    tbl[24] = mk(0,1,1,0,32'h0,            1,RPC+32'h20C,   1,RPC+32'h200);

    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr_out", instr_out, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].st, tbl[i].rd, tbl[i].rs, tbl[i].rv, tbl[i].rpc);
      @(negedge clk);
      check($sformatf("tbl%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) check($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_valid_out", i), {31'd0, valid_out}, {31'd0, tbl[i].e_vout});
      check($sformatf("tbl%0d_pc_out", i), pc_out, tbl[i].e_pc);
      observe();
      tick();
    end

    // Fill the FIFO under stall, then reset asynchronously while full.
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      if (k == 5) begin
        check("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("full_valid_out", {31'd0, valid_out}, 32'd1);
        check("full_pc_out", pc_out, RPC + 32'h204);
      end
      observe();
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("async_valid_out", {31'd0, valid_out}, 32'd0);
    check("async_pc_out", pc_out, 32'h0);
    check("async_instr_out", instr_out, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
    observe();
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("refetch_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("refetch_req_addr", imem_req_addr, RPC);
    observe();
    tick();

    for (int n = 0; n < 3000; n++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 29) == 0);
      rpc = RPC | ($urandom & 32'h0000_3FFF);
      drive(st, rd, rs, rv, rpc);
      @(negedge clk);
      observe();
      tick();
    end
    check("progress", {31'd0, pops > 200}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
